// File: rtl/vending_controller_multi_if.sv
`default_nettype none
// vending_controller_multi_if: coin/button front end and actuator signals of the multi-slot vending controller.
// Rev 1.0
interface vending_controller_multi_if #(
  parameter int NUM_ITEMS = 4,
  parameter int PRICE_W   = 8,
  parameter int STOCK_W   = 4
);
  localparam int IDX_W = $clog2(NUM_ITEMS);

  logic               coin_5;
  logic               coin_10;
  logic               coin_25;
  logic               next_item;
  logic               select;
  logic               cancel;
  logic               price_wr_en;
  logic [IDX_W-1:0]   price_wr_idx;
  logic [PRICE_W-1:0] price_wr_data;
  logic               restock_en;
  logic [IDX_W-1:0]   restock_idx;
  logic [STOCK_W-1:0] restock_qty;

  logic [IDX_W-1:0]   selected_item;
  logic [PRICE_W-1:0] credit;
  logic               dispense;
  logic [IDX_W-1:0]   dispense_item;
  logic               change_5;
  logic               change_10;
  logic               change_25;
  logic               coin_reject;
  logic               sold_out;
  logic               busy;

  modport master (
    output coin_5, coin_10, coin_25, next_item, select, cancel,
           price_wr_en, price_wr_idx, price_wr_data,
           restock_en, restock_idx, restock_qty,
    input  selected_item, credit, dispense, dispense_item,
           change_5, change_10, change_25, coin_reject, sold_out, busy
  );

  modport slave (
    input  coin_5, coin_10, coin_25, next_item, select, cancel,
           price_wr_en, price_wr_idx, price_wr_data,
           restock_en, restock_idx, restock_qty,
    output selected_item, credit, dispense, dispense_item,
           change_5, change_10, change_25, coin_reject, sold_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/vending_controller_multi.sv
`default_nettype none
// vending_controller_multi: multi-slot vending FSM with programmable prices, stock tracking and greedy change payout.
// Rev 1.0
module vending_controller_multi #(
  parameter int NUM_ITEMS  = 4,
  parameter int PRICE_W    = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  parameter int BASE_PRICE = 25
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  vending_controller_multi_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_ITEMS);
  localparam int SUM_W = PRICE_W + 6;

  localparam logic [PRICE_W-1:0] CREDIT_MAX = '1;
  localparam logic [STOCK_W-1:0] STOCK_MAX  = '1;
  localparam logic [PRICE_W-1:0] COIN_5     = PRICE_W'(5);
  localparam logic [PRICE_W-1:0] COIN_10    = PRICE_W'(10);
  localparam logic [PRICE_W-1:0] COIN_25    = PRICE_W'(25);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_COLLECTING = 2'd1,
    ST_DISPENSE   = 2'd2,
    ST_CHANGE     = 2'd3
  } state_t;

  function automatic logic [PRICE_W-1:0] reset_price(input int slot);
    longint p;
    p = longint'(BASE_PRICE) * longint'(slot + 1);
    if (p > longint'(CREDIT_MAX)) begin
      return CREDIT_MAX;
    end
    return PRICE_W'(p);
  endfunction

  function automatic logic [PRICE_W-1:0] greedy_coin(input logic [PRICE_W-1:0] amount);
    if (amount >= COIN_25) begin
      return COIN_25;
    end else if (amount >= COIN_10) begin
      return COIN_10;
    end else if (amount >= COIN_5) begin
      return COIN_5;
    end
    return '0;
  endfunction

  state_t             state_q, state_d;
  logic [PRICE_W-1:0] credit_q, credit_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               next_prev_q, next_prev_d;
  logic [PRICE_W-1:0] price_q [NUM_ITEMS];
  logic [PRICE_W-1:0] price_d [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_d [NUM_ITEMS];
  logic               dispense_q, dispense_d;
  logic [IDX_W-1:0]   dispense_item_q, dispense_item_d;
  logic               change_5_q, change_5_d;
  logic               change_10_q, change_10_d;
  logic               change_25_q, change_25_d;
  logic               coin_reject_q, coin_reject_d;
  logic               sold_out_q, sold_out_d;
  logic               busy_q, busy_d;

  logic [SUM_W-1:0]   coin_sum;
  logic [SUM_W-1:0]   credit_plus;
  logic               coin_any;
  logic               coin_fits;
  logic               next_edge;
  logic [PRICE_W-1:0] sel_price;
  logic [STOCK_W-1:0] sel_stock;
  logic [STOCK_W:0]   restock_sum;
  logic [PRICE_W-1:0] remainder;
  logic [PRICE_W-1:0] payout_coin;
  logic               coins_open;

  assign coin_sum    = (bus.coin_5  ? SUM_W'(5)  : SUM_W'(0))
                     + (bus.coin_10 ? SUM_W'(10) : SUM_W'(0))
                     + (bus.coin_25 ? SUM_W'(25) : SUM_W'(0));
  assign credit_plus = SUM_W'(credit_q) + coin_sum;
  assign coin_any    = bus.coin_5 | bus.coin_10 | bus.coin_25;
  assign coin_fits   = (credit_plus <= SUM_W'(CREDIT_MAX));
  assign next_edge   = bus.next_item & ~next_prev_q;
  assign sel_price   = price_q[sel_q];
  assign sel_stock   = stock_q[sel_q];
  assign restock_sum = {1'b0, stock_q[bus.restock_idx]} + {1'b0, bus.restock_qty};

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    sel_d           = sel_q;
    next_prev_d     = bus.next_item;
    price_d         = price_q;
    stock_d         = stock_q;
    dispense_d      = 1'b0;
    dispense_item_d = dispense_item_q;
    change_5_d      = 1'b0;
    change_10_d     = 1'b0;
    change_25_d     = 1'b0;
    coin_reject_d   = 1'b0;
    sold_out_d      = 1'b0;
    remainder       = '0;
    payout_coin     = '0;
    coins_open      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        coins_open = 1'b1;
        if (next_edge) begin
          sel_d = (sel_q == IDX_W'(NUM_ITEMS - 1)) ? '0 : sel_q + IDX_W'(1);
        end
        if (bus.price_wr_en) begin
          price_d[bus.price_wr_idx] = bus.price_wr_data;
        end
        if (bus.restock_en) begin
          stock_d[bus.restock_idx] = restock_sum[STOCK_W] ? STOCK_MAX
                                                          : restock_sum[STOCK_W-1:0];
        end
      end

      ST_COLLECTING: begin
        coins_open = 1'b1;
        if (next_edge) begin
          sel_d = (sel_q == IDX_W'(NUM_ITEMS - 1)) ? '0 : sel_q + IDX_W'(1);
        end
        // Coins arriving with a cancel or an accepted sale are handed back untouched.
        if (bus.cancel) begin
          coins_open = 1'b0;
          if (credit_q >= COIN_5) begin
            state_d = ST_CHANGE;
          end else begin
            state_d  = ST_IDLE;
            credit_d = '0;
          end
        end else if (bus.select && (sel_stock == '0)) begin
          sold_out_d = 1'b1;
        end else if (bus.select && (credit_q >= sel_price)) begin
          coins_open      = 1'b0;
          state_d         = ST_DISPENSE;
          dispense_d      = 1'b1;
          dispense_item_d = sel_q;
        end
      end

      ST_DISPENSE: begin
        remainder                = credit_q - price_q[dispense_item_q];
        stock_d[dispense_item_q] = stock_q[dispense_item_q] - STOCK_W'(1);
        if (remainder >= COIN_5) begin
          state_d  = ST_CHANGE;
          credit_d = remainder;
        end else begin
          state_d  = ST_IDLE;
          credit_d = '0;
        end
      end

      ST_CHANGE: begin
        remainder = credit_q - greedy_coin(credit_q);
        if (remainder >= COIN_5) begin
          credit_d = remainder;
        end else begin
          state_d  = ST_IDLE;
          credit_d = '0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase

    if (coin_any) begin
      if (coins_open && coin_fits) begin
        credit_d = credit_plus[PRICE_W-1:0];
        if (state_q == ST_IDLE) begin
          state_d = ST_COLLECTING;
        end
      end else begin
        coin_reject_d = 1'b1;
      end
    end

    // Strobes are registered, so the coin shown during a CHANGE cycle is picked from the credit entering it.
    if (state_d == ST_CHANGE) begin
      payout_coin = greedy_coin(credit_d);
      change_25_d = (payout_coin == COIN_25);
      change_10_d = (payout_coin == COIN_10);
      change_5_d  = (payout_coin == COIN_5);
    end

    busy_d = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      credit_q        <= '0;
      sel_q           <= '0;
      next_prev_q     <= 1'b0;
      dispense_q      <= 1'b0;
      dispense_item_q <= '0;
      change_5_q      <= 1'b0;
      change_10_q     <= 1'b0;
      change_25_q     <= 1'b0;
      coin_reject_q   <= 1'b0;
      sold_out_q      <= 1'b0;
      busy_q          <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        price_q[i] <= reset_price(i);
        stock_q[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      sel_q           <= sel_d;
      next_prev_q     <= next_prev_d;
      price_q         <= price_d;
      stock_q         <= stock_d;
      dispense_q      <= dispense_d;
      dispense_item_q <= dispense_item_d;
      change_5_q      <= change_5_d;
      change_10_q     <= change_10_d;
      change_25_q     <= change_25_d;
      coin_reject_q   <= coin_reject_d;
      sold_out_q      <= sold_out_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.selected_item = sel_q;
  assign bus.credit        = credit_q;
  assign bus.dispense      = dispense_q;
  assign bus.dispense_item = dispense_item_q;
  assign bus.change_5      = change_5_q;
  assign bus.change_10     = change_10_q;
  assign bus.change_25     = change_25_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.sold_out      = sold_out_q;
  assign bus.busy          = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_vending_controller_multi.sv
`default_nettype none
// tb_vending_controller_multi: directed and randomized checks of vending_controller_multi against a transaction-level model.
// Rev 1.0
module tb_vending_controller_multi;
  localparam int NUM_ITEMS  = 4;
  localparam int PRICE_W    = 8;
  localparam int STOCK_W    = 4;
  localparam int INIT_STOCK = 5;
  localparam int BASE_PRICE = 25;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vending_controller_multi_if #(
    .NUM_ITEMS (NUM_ITEMS),
    .PRICE_W   (PRICE_W),
    .STOCK_W   (STOCK_W)
  ) bus ();

  vending_controller_multi #(
    .NUM_ITEMS  (NUM_ITEMS),
    .PRICE_W    (PRICE_W),
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK),
    .BASE_PRICE (BASE_PRICE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: whole-unit credit, selection, prices and stock.
  int m_credit;
  int m_sel;
  int m_price [NUM_ITEMS];
  int m_stock [NUM_ITEMS];
  int n_pass  = 0;
  int n_total = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.coin_5        = 1'b0;
    bus.coin_10       = 1'b0;
    bus.coin_25       = 1'b0;
    bus.next_item     = 1'b0;
    bus.select        = 1'b0;
    bus.cancel        = 1'b0;
    bus.price_wr_en   = 1'b0;
    bus.price_wr_idx  = '0;
    bus.price_wr_data = '0;
    bus.restock_en    = 1'b0;
    bus.restock_idx   = '0;
    bus.restock_qty   = '0;
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_sel    = 0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      m_price[i] = (BASE_PRICE * (i + 1) > 255) ? 255 : BASE_PRICE * (i + 1);
      m_stock[i] = INIT_STOCK;
    end
  endtask

  function automatic logic [18:0] observed();
    return {bus.selected_item, bus.credit, bus.dispense,
            (bus.dispense ? bus.dispense_item : 2'd0),
            bus.change_25, bus.change_10, bus.change_5,
            bus.coin_reject, bus.sold_out, bus.busy};
  endfunction

  function automatic logic [18:0] expected(int credit, bit disp, int item, int coin,
                                           bit rej, bit so, bit busy);
    logic [2:0] strobes;
    strobes = (coin == 25) ? 3'b100 : (coin == 10) ? 3'b010 : (coin == 5) ? 3'b001 : 3'b000;
    return {2'(m_sel), 8'(credit), disp, 2'(disp ? item : 0), strobes, rej, so, busy};
  endfunction

  task automatic check(input string tag, input logic [18:0] exp_v);
    logic [18:0] obs_v;
    obs_v = observed();
    n_total++;
    assert (obs_v === exp_v) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  task automatic check_quiet(input string tag);
    check(tag, expected(m_credit, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0));
  endtask

  // Greedy payout of amount, one coin per cycle, first coin already on the outputs.
  task automatic run_change(input string tag, input int amount);
    int left;
    int coin;
    left = amount;
    while (left >= 5) begin
      coin = (left >= 25) ? 25 : (left >= 10) ? 10 : 5;
      check({tag, "_change"}, expected(left, 1'b0, 0, coin, 1'b0, 1'b0, 1'b1));
      left -= coin;
      step();
    end
    m_credit = 0;
    check_quiet({tag, "_done"});
  endtask

  task automatic op_coin(input bit c5, input bit c10, input bit c25);
    int sum;
    bit rej;
    bus.coin_5  = c5;
    bus.coin_10 = c10;
    bus.coin_25 = c25;
    step();
    clear_inputs();
    sum = (c5 ? 5 : 0) + (c10 ? 10 : 0) + (c25 ? 25 : 0);
    rej = 1'b0;
    if (sum != 0) begin
      if (m_credit + sum > 255) rej = 1'b1;
      else m_credit += sum;
    end
    check("coin", expected(m_credit, 1'b0, 0, 0, rej, 1'b0, 1'b0));
  endtask

  task automatic op_next();
    bus.next_item = 1'b1;
    step();
    m_sel = (m_sel + 1) % NUM_ITEMS;
    check_quiet("next_item");
    bus.next_item = 1'b0;
    step();
    check_quiet("next_release");
  endtask

  task automatic op_select();
    int rem;
    bus.select = 1'b1;
    step();
    clear_inputs();
    if (m_credit == 0) begin
      check_quiet("select_idle");
    end else if (m_stock[m_sel] == 0) begin
      check("sold_out", expected(m_credit, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0));
    end else if (m_credit >= m_price[m_sel]) begin
      check("dispense", expected(m_credit, 1'b1, m_sel, 0, 1'b0, 1'b0, 1'b1));
      rem = m_credit - m_price[m_sel];
      m_stock[m_sel]--;
      step();
      run_change("vend", rem);
    end else begin
      check_quiet("select_short");
    end
  endtask

  task automatic op_cancel(input bit with_select);
    bus.cancel = 1'b1;
    bus.select = with_select;
    step();
    clear_inputs();
    if (m_credit == 0) check_quiet("cancel_idle");
    else run_change("cancel", m_credit);
  endtask

  task automatic op_price(input int idx, input int data);
    bus.price_wr_en   = 1'b1;
    bus.price_wr_idx  = 2'(idx);
    bus.price_wr_data = 8'(data);
    step();
    clear_inputs();
    if (m_credit == 0) m_price[idx] = data;
    check_quiet("price_write");
  endtask

  task automatic op_restock(input int idx, input int qty);
    bus.restock_en  = 1'b1;
    bus.restock_idx = 2'(idx);
    bus.restock_qty = 4'(qty);
    step();
    clear_inputs();
    if (m_credit == 0) m_stock[idx] = (m_stock[idx] + qty > 15) ? 15 : m_stock[idx] + qty;
    check_quiet("restock");
  endtask

  initial begin
    int op;
    bit [2:0] mask;
    reset = 1'b0;
    clear_inputs();
    model_reset();
    step();
    step();
    check_quiet("reset");
    reset = 1'b1;
    step();
    check_quiet("post_reset");

    // Slot 1 at price 50, exact credit.
    op_coin(0, 0, 1);
    op_coin(0, 0, 1);
    op_next();
    op_select();

    // 75 into slot 0 at price 25 pays back 25, 25.
    op_coin(0, 0, 1);
    op_coin(0, 0, 1);
    op_coin(0, 0, 1);
    op_next();
    op_next();
    op_next();
    op_select();

    // Cancel beats a simultaneous select.
    op_coin(0, 1, 0);
    op_coin(1, 0, 0);
    op_cancel(1'b1);

    // Empty slot 2, then sold_out with 100 of credit.
    op_next();
    op_next();
    for (int k = 0; k < 5; k++) begin
      op_coin(0, 0, 1);
      op_coin(0, 0, 1);
      op_coin(0, 0, 1);
      op_select();
    end
    op_price(3, 200);
    for (int k = 0; k < 4; k++) op_coin(0, 0, 1);
    op_select();
    op_next();
    op_select();
    op_cancel(1'b0);

    // Credit ceiling and selection wrap.
    for (int k = 0; k < 10; k++) op_coin(0, 0, 1);
    op_coin(0, 1, 0);
    op_coin(1, 1, 1);
    for (int k = 0; k < 4; k++) op_next();
    op_cancel(1'b0);

    // Reset in the middle of paying out 40.
    op_coin(0, 0, 1);
    op_coin(0, 1, 0);
    op_coin(1, 0, 0);
    bus.cancel = 1'b1;
    step();
    clear_inputs();
    check("change_before_reset", expected(40, 1'b0, 0, 25, 1'b0, 1'b0, 1'b1));
    reset = 1'b0;
    step();
    model_reset();
    check_quiet("reset_mid_change");
    reset = 1'b1;
    step();
    check_quiet("after_reset_release");

    // Price write ignored while collecting, then a zero-price vend.
    op_coin(1, 0, 0);
    op_price(0, 5);
    op_select();
    op_cancel(1'b0);
    op_price(1, 0);
    op_next();
    op_select();
    op_coin(1, 0, 0);
    op_select();
    op_restock(2, 15);
    op_restock(2, 3);

    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 99));
      if (op < 40) begin
        mask = 3'($urandom_range(1, 7));
        op_coin(mask[0], mask[1], mask[2]);
      end else if (op < 50) begin
        op_next();
      end else if (op < 70) begin
        op_select();
      end else if (op < 75) begin
        op_cancel(1'($urandom_range(0, 1)));
      end else if (op < 85) begin
        op_price(int'($urandom_range(0, NUM_ITEMS - 1)), int'($urandom_range(0, 150)));
      end else if (op < 95) begin
        op_restock(int'($urandom_range(0, NUM_ITEMS - 1)), int'($urandom_range(0, 15)));
      end else begin
        step();
        check_quiet("idle_cycle");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
